// File: rtl/isp_mosaic_l.sv
// rtl/isp_mosaic_l.sv - full-colour to Bayer mosaic with 2-cycle pipeline and frame_done pulse
// Optional geometry checking (err_width/err_height) compiled in with ISP_MOSAIC_FRAMECHK_EN.
module isp_mosaic_l #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960,
  parameter int BAYER  = 0
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic            in_de,
  input  logic [BITS-1:0] in_r,
  input  logic [BITS-1:0] in_g,
  input  logic [BITS-1:0] in_b,
  output logic            out_href,
  output logic            out_vsync,
  output logic            out_de,
  output logic [BITS-1:0] out_raw,
  output logic            frame_done,
  output logic            err_width,
  output logic            err_height
);

  localparam logic [1:0] PAT = 2'(BAYER);

  logic            pix_par, line_par, href_d, vsync_d, line_seen;
  logic [2:0]      tim1, tim2;
  logic [BITS-1:0] s1, s2;
  logic            fd1, fd2;
  logic [1:0]      fmt;
  logic [BITS-1:0] sel;
  logic            href_fall, vsync_rise;

  always_comb begin
    fmt        = PAT ^ {line_par, pix_par};
    href_fall  = href_d & ~in_href;
    vsync_rise = in_vsync & ~vsync_d;
    case (fmt)
      2'd0:    sel = in_r;
      2'd3:    sel = in_b;
      default: sel = in_g;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pix_par   <= 1'b0;
      line_par  <= 1'b0;
      href_d    <= 1'b0;
      vsync_d   <= 1'b0;
      line_seen <= 1'b0;
      tim1      <= '0;
      tim2      <= '0;
      s1        <= '0;
      s2        <= '0;
      fd1       <= 1'b0;
      fd2       <= 1'b0;
    end else begin
      pix_par <= in_href ? ~pix_par : 1'b0;
      if (in_vsync)
        line_par <= 1'b0;
      else if (href_fall)
        line_par <= ~line_par;
      href_d  <= in_href;
      vsync_d <= in_vsync;
      tim1    <= {in_href, in_vsync, in_de};
      tim2    <= tim1;
      s1      <= sel;
      // Blank the sample outside active line so out_raw is 0 whenever out_href is 0.
      s2      <= tim1[2] ? s1 : '0;
      // A line ending in the same cycle as the vsync rise still belongs to the closing frame.
      fd1     <= vsync_rise & (line_seen | href_fall);
      fd2     <= fd1;
      if (vsync_rise)
        line_seen <= 1'b0;
      else if (href_fall)
        line_seen <= 1'b1;
    end
  end

  assign out_href   = tim2[2];
  assign out_vsync  = tim2[1];
  assign out_de     = tim2[0];
  assign out_raw    = s2;
  assign frame_done = fd2;

`ifdef ISP_MOSAIC_FRAMECHK_EN
  localparam int PW = $clog2(WIDTH + 2);
  localparam int LW = $clog2(HEIGHT + 2);

  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt, line_cnt_inc;
  logic          errw_q, errh_q;

  always_comb begin
    line_cnt_inc = line_cnt;
    if (href_fall && line_cnt != '1)
      line_cnt_inc = line_cnt + 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      errw_q   <= 1'b0;
      errh_q   <= 1'b0;
    end else begin
      if (href_fall) begin
        pix_cnt <= '0;
        if (pix_cnt != PW'(WIDTH))
          errw_q <= 1'b1;
      end else if (in_href && pix_cnt != '1) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (vsync_rise) begin
        if (line_cnt_inc != '0 && line_cnt_inc != LW'(HEIGHT))
          errh_q <= 1'b1;
        line_cnt <= '0;
      end else begin
        line_cnt <= line_cnt_inc;
      end
    end
  end

  assign err_width  = errw_q;
  assign err_height = errh_q;
`else
  assign err_width  = 1'b0;
  assign err_height = 1'b0;
`endif

endmodule
